// File: rtl/irq_agg_pkg.sv
// Shared FSM state type and default sizing for the interrupt aggregator.
// No datapath of its own; imported by irq_aggregator and irq_holdoff_fsm.
package irq_agg_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } irq_agg_state_t;

  localparam int N_SRC_DEF     = 8;
  localparam int HOLDOFF_W_DEF = 12;
  localparam int CNT_W_DEF     = 16;

endpackage

// File: rtl/irq_holdoff_fsm.sv
// Level-interrupt FSM: asserts one cycle after status goes nonzero, then rate-limits re-assertion.
// Registered irq_out; no backpressure, holdoff_cycles is sampled on leaving ASSERT.
module irq_holdoff_fsm
  import irq_agg_pkg::*;
#(
  parameter int HOLDOFF_W = HOLDOFF_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 any_status,
  input  logic [HOLDOFF_W-1:0] holdoff_cycles,
  output logic                 irq_out
);

  irq_agg_state_t       state_q;
  logic [HOLDOFF_W-1:0] hcnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      irq_out <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_status) begin
            state_q <= ASSERT;
            irq_out <= 1'b1;
          end
        end
        ASSERT: begin
          if (!any_status) begin
            irq_out <= 1'b0;
            if (holdoff_cycles == '0) begin
              state_q <= IDLE;
            end else begin
              // Loading N-1 makes HOLDOFF last exactly N cycles before IDLE.
              state_q <= HOLDOFF;
              hcnt_q  <= holdoff_cycles - HOLDOFF_W'(1);
            end
          end
        end
        HOLDOFF: begin
          if (hcnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            hcnt_q <= hcnt_q - HOLDOFF_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          irq_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/irq_aggregator.sv
// Latches per-source irq pulses into pending/overflow, masks by enable, drives one rate-limited level irq.
// Pulse->pending 1 cycle, pending->irq_out 1 cycle; no backpressure. IRQ_COUNT_EN adds saturating event counters.
module irq_aggregator
  import irq_agg_pkg::*;
#(
  parameter  int N_SRC     = N_SRC_DEF,
  parameter  int HOLDOFF_W = HOLDOFF_W_DEF,
  parameter  int CNT_W     = CNT_W_DEF,
  localparam int SEL_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_SRC-1:0]     irq_pulse,
  input  logic                 en_wr,
  input  logic [N_SRC-1:0]     en_wdata,
  input  logic                 clr_wr,
  input  logic [N_SRC-1:0]     clr_wdata,
  input  logic [HOLDOFF_W-1:0] holdoff_cycles,
  output logic [N_SRC-1:0]     enable,
  output logic [N_SRC-1:0]     pending,
  output logic [N_SRC-1:0]     status,
  output logic [N_SRC-1:0]     overflow,
  output logic                 irq_out,
  input  logic [SEL_W-1:0]     cnt_sel,
  input  logic                 cnt_clr,
  output logic [CNT_W-1:0]     cnt_data
);

  logic [N_SRC-1:0] clr_hit;

  assign clr_hit = clr_wr ? clr_wdata : '0;
  assign status  = pending & enable;

  // A pulse coincident with a clear wins for pending, so no event is lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      enable   <= '0;
      pending  <= '0;
      overflow <= '0;
    end else begin
      if (en_wr) begin
        enable <= en_wdata;
      end
      pending  <= (pending & ~clr_hit) | irq_pulse;
      overflow <= (overflow | (irq_pulse & pending)) & ~clr_hit;
    end
  end

  irq_holdoff_fsm #(
    .HOLDOFF_W (HOLDOFF_W)
  ) u_fsm (
    .clk            (clk),
    .rst_n          (rst_n),
    .any_status     (|status),
    .holdoff_cycles (holdoff_cycles),
    .irq_out        (irq_out)
  );

`ifdef IRQ_COUNT_EN
  // Array padded to a power of two so any cnt_sel value reads a defined (zero) slot.
  localparam int N_SLOT = 1 << SEL_W;

  logic [N_SLOT-1:0] pulse_ext;
  logic [CNT_W-1:0]  cnt_q [N_SLOT];

  assign pulse_ext = N_SLOT'(irq_pulse);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_SLOT; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_SLOT; i++) begin
        if (cnt_clr && (cnt_sel == SEL_W'(i))) begin
          cnt_q[i] <= CNT_W'(pulse_ext[i]);
        end else if (pulse_ext[i] && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  assign cnt_data = cnt_q[cnt_sel];
`else
  logic unused_cnt;

  assign unused_cnt = ^{cnt_sel, cnt_clr};
  assign cnt_data   = '0;
`endif

endmodule

// File: tb/tb_irq_aggregator.sv
// Scoreboard bench for irq_aggregator: per-cycle expectations queued at drive time, popped after each edge.
// Counter checks follow IRQ_COUNT_EN; directed checks carry constants from the intended behaviour.
module tb_irq_aggregator;

  localparam int N  = 8;
  localparam int HW = 12;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N-1:0]  irq_pulse;
  logic          en_wr;
  logic [N-1:0]  en_wdata;
  logic          clr_wr;
  logic [N-1:0]  clr_wdata;
  logic [HW-1:0] holdoff_cycles;
  logic [N-1:0]  enable;
  logic [N-1:0]  pending;
  logic [N-1:0]  status;
  logic [N-1:0]  overflow;
  logic          irq_out;
  logic [2:0]    cnt_sel;
  logic          cnt_clr;
  logic [CW-1:0] cnt_data;

  irq_aggregator #(
    .N_SRC     (N),
    .HOLDOFF_W (HW),
    .CNT_W     (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .irq_pulse      (irq_pulse),
    .en_wr          (en_wr),
    .en_wdata       (en_wdata),
    .clr_wr         (clr_wr),
    .clr_wdata      (clr_wdata),
    .holdoff_cycles (holdoff_cycles),
    .enable         (enable),
    .pending        (pending),
    .status         (status),
    .overflow       (overflow),
    .irq_out        (irq_out),
    .cnt_sel        (cnt_sel),
    .cnt_clr        (cnt_clr),
    .cnt_data       (cnt_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  pend;
    logic [N-1:0]  ovf;
    logic [N-1:0]  en;
    logic [N-1:0]  stat;
    logic          irq;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state (0=IDLE, 1=ASSERT, 2=HOLDOFF)
  logic [N-1:0] m_pend, m_ovf, m_en;
  logic         m_irq;
  int           m_st, m_hc;
  int           m_cnt [N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    logic any;
    any = |(m_pend & m_en);
    if (!rst_n) begin
      m_pend = '0; m_ovf = '0; m_en = '0;
      m_st = 0; m_hc = 0; m_irq = 1'b0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
    end else begin
      for (int i = 0; i < N; i++) begin
        logic c;
        c = clr_wr && clr_wdata[i];
        if (irq_pulse[i] && m_pend[i] && !c) m_ovf[i] = 1'b1;
        if (c) m_ovf[i] = 1'b0;
        if (irq_pulse[i]) m_pend[i] = 1'b1;
        else if (c) m_pend[i] = 1'b0;
        if (cnt_clr && (int'(cnt_sel) == i)) m_cnt[i] = irq_pulse[i] ? 1 : 0;
        else if (irq_pulse[i] && m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
      end
      if (en_wr) m_en = en_wdata;
      case (m_st)
        0: if (any) begin m_st = 1; m_irq = 1'b1; end
        1: if (!any) begin
             m_irq = 1'b0;
             if (holdoff_cycles == 0) m_st = 0;
             else begin m_st = 2; m_hc = int'(holdoff_cycles) - 1; end
           end
        default: if (m_hc == 0) m_st = 0; else m_hc--;
      endcase
    end
  endtask

  task automatic tick();
    exp_t e;
    model_step();
    e.pend = m_pend;
    e.ovf  = m_ovf;
    e.en   = m_en;
    e.stat = m_pend & m_en;
    e.irq  = m_irq;
`ifdef IRQ_COUNT_EN
    e.cnt  = CW'(m_cnt[cnt_sel]);
`else
    e.cnt  = '0;
`endif
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("sb_pending", 32'(pending), 32'(e.pend));
    check("sb_overflow", 32'(overflow), 32'(e.ovf));
    check("sb_enable", 32'(enable), 32'(e.en));
    check("sb_status", 32'(status), 32'(e.stat));
    check("sb_irq_out", 32'(irq_out), 32'(e.irq));
    check("sb_cnt_data", 32'(cnt_data), 32'(e.cnt));
  endtask

  task automatic idle_in();
    irq_pulse = '0; en_wr = 1'b0; clr_wr = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic wr_en(input logic [N-1:0] v);
    en_wr = 1'b1; en_wdata = v; tick(); en_wr = 1'b0;
  endtask

  task automatic clr(input logic [N-1:0] v);
    clr_wr = 1'b1; clr_wdata = v; tick(); clr_wr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int low;
    rst_n = 1'b0; irq_pulse = '0; en_wr = 1'b0; en_wdata = '0;
    clr_wr = 1'b0; clr_wdata = '0; holdoff_cycles = '0;
    cnt_sel = '0; cnt_clr = 1'b0;
    #2;
    tick(); tick();
    check("rst_irq", 32'(irq_out), 32'h0);
    check("rst_pending", 32'(pending), 32'h0);
    rst_n = 1'b1;

    // Basic pulse -> pending -> irq -> clear with no holdoff
    wr_en(8'h01);
    irq_pulse = 8'h01; tick(); idle_in();
    check("tp1_pend_t1", 32'(pending), 32'h01);
    check("tp1_irq_t1", 32'(irq_out), 32'h0);
    tick();
    check("tp1_irq_t2", 32'(irq_out), 32'h1);
    clr(8'h01);
    tick();
    check("tp1_irq_drop", 32'(irq_out), 32'h0);
    tick();
    check("tp1_irq_idle", 32'(irq_out), 32'h0);

    // Overflow, then clear racing a new pulse
    irq_pulse = 8'h08; tick(); tick(); idle_in();
    check("tp2_overflow", 32'(overflow), 32'h08);
    clr_wr = 1'b1; clr_wdata = 8'h08; irq_pulse = 8'h08; tick(); idle_in();
    check("tp2_pend_kept", 32'(pending & 8'h08), 32'h08);
    check("tp2_ovf_clr", 32'(overflow & 8'h08), 32'h0);
    clr(8'h08);

    // Masked source latches, irq follows enable write
    wr_en(8'h00);
    irq_pulse = 8'h20; tick(); idle_in();
    check("tp3_pend", 32'(pending), 32'h20);
    tick(); tick();
    check("tp3_irq_masked", 32'(irq_out), 32'h0);
    wr_en(8'h20);
    check("tp3_irq_w1", 32'(irq_out), 32'h0);
    tick();
    check("tp3_irq_w2", 32'(irq_out), 32'h1);
    clr(8'h20); tick(); tick();

    // Holdoff of 4 with an event arriving during holdoff
    holdoff_cycles = 12'd4;
    wr_en(8'h01);
    irq_pulse = 8'h01; tick(); idle_in(); tick();
    check("tp4_irq_up", 32'(irq_out), 32'h1);
    clr(8'h01);
    check("tp4_irq_at_clr", 32'(irq_out), 32'h1);
    irq_pulse = 8'h01;
    low = 0;
    for (int k = 0; k < 20; k++) begin
      tick(); idle_in();
      if (irq_out === 1'b1) break;
      low++;
    end
    check("tp4_low_cycles", 32'(low), 32'd5);
    check("tp4_reassert", 32'(irq_out), 32'h1);

    // Holdoff of 1: one HOLDOFF cycle plus one IDLE cycle low
    clr(8'h01);
    for (int k = 0; k < 8; k++) tick();
    holdoff_cycles = 12'd1;
    irq_pulse = 8'h01; tick(); idle_in(); tick();
    check("ho1_irq_up", 32'(irq_out), 32'h1);
    clr(8'h01);
    irq_pulse = 8'h01;
    low = 0;
    for (int k = 0; k < 20; k++) begin
      tick(); idle_in();
      if (irq_out === 1'b1) break;
      low++;
    end
    check("ho1_low_cycles", 32'(low), 32'd2);
    clr(8'h01);
    for (int k = 0; k < 4; k++) tick();
    holdoff_cycles = 12'd0;

    // Reset during ASSERT with everything pending
    wr_en(8'hFF);
    irq_pulse = 8'hFF; tick(); idle_in(); tick();
    check("tp5_pend_all", 32'(pending), 32'hFF);
    check("tp5_irq_up", 32'(irq_out), 32'h1);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("tp5_rst_irq", 32'(irq_out), 32'h0);
    check("tp5_rst_pend", 32'(pending), 32'h0);
    check("tp5_rst_en", 32'(enable), 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("tp5_no_spurious", 32'(irq_out), 32'h0);
    end

    // Event counter saturation and clear racing a pulse
    cnt_sel = 3'd2;
    for (int k = 0; k < 17; k++) begin
      irq_pulse = 8'h04; tick();
    end
    idle_in();
`ifdef IRQ_COUNT_EN
    check("tp6_cnt_sat", 32'(cnt_data), 32'd15);
`else
    check("tp6_cnt_tied", 32'(cnt_data), 32'd0);
`endif
    cnt_clr = 1'b1; irq_pulse = 8'h04; tick(); idle_in();
`ifdef IRQ_COUNT_EN
    check("tp6_cnt_clr_pulse", 32'(cnt_data), 32'd1);
`else
    check("tp6_cnt_clr_tied", 32'(cnt_data), 32'd0);
`endif
    cnt_sel = 3'd5; tick();
    check("tp6_cnt_other", 32'(cnt_data), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
